// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    // x0 is hard-wired to zero, so it never carries a real dependence.
    localparam logic [REG_ADDR_W_DEF-1:0] X0 = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hdu_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones instead of wrapping.
// Latency: count reflects events up to the previous rising edge of clk.
// Backpressure: none; inc is sampled every cycle.
//   clk, reset (async active-high, clears count), inc (count this cycle), count (W bits)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory freeze, perf counters.
// Latency: enables/flushes are combinational in the same cycle; counters lag by one edge.
// Backpressure: mem_busy freezes every pipeline register; it outranks branch flush and load-use stall.
//   Inputs : clk, reset, ID sources (if_id_rs1/rs2 + uses), EX load info (id_ex_MemRead, id_ex_rd),
//            ex_branch_taken, mem_busy
//   Outputs: PCWrite, IF_ID/ID_EX/EX_MEM/MEM_WB_Write, IF_ID_Flush, ID_EX_Flush,
//            stall_cycles, flush_count
module hazard_detection_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_uses_rs1,
    input  logic                  if_id_uses_rs2,
    input  logic                  id_ex_MemRead,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Write,
    output logic                  EX_MEM_Write,
    output logic                  MEM_WB_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    hdu_state_t state, state_next;
    logic       lu;
    logic       lu_eff;
    logic       branch_flush;

    // Load in EX whose result the ID instruction actually reads; forwarding cannot cover this.
    assign lu = id_ex_MemRead
              && (id_ex_rd != REG_ADDR_W'(X0))
              && ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd))
               || (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = RUN;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        branch_flush = 1'b0;

        // The cycle after a load-use stall the bubble sits in EX, so the stale
        // id_ex fields must not trigger a second stall. MEM_WAIT with memory
        // ready behaves exactly like RUN, so only LOAD_STALL gates lu.
        unique case (state)
            LOAD_STALL: lu_eff = 1'b0;
            default:    lu_eff = lu;
        endcase

        if (reset) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
        end else if (mem_busy) begin
            // Full freeze; branch and lu are re-presented by the held EX instruction later.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
            state_next   = MEM_WAIT;
        end else if (ex_branch_taken) begin
            // PC keeps writing so the branch target is fetched next.
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            branch_flush = 1'b1;
            state_next   = RUN;
        end else if (lu_eff) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            state_next   = LOAD_STALL;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~PCWrite),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a rule-level model.
module tb_hazard_detection_unit;

    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Output vector order: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write, IF_ID_Flush, ID_EX_Flush
    localparam logic [6:0] O_RESET  = 7'b0000011;
    localparam logic [6:0] O_FREEZE = 7'b0000000;
    localparam logic [6:0] O_BRANCH = 7'b1111111;
    localparam logic [6:0] O_LU     = 7'b0011101;
    localparam logic [6:0] O_DEF    = 7'b1111100;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic          if_id_uses_rs1, if_id_uses_rs2, id_ex_MemRead;
    logic          ex_branch_taken, mem_busy;
    logic          PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
    logic          IF_ID_Flush, ID_EX_Flush;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [6:0]    outs;

    int checks = 0;
    int errors = 0;

    // Model state: whether the previous cycle was an effective load-use stall, and event tallies.
    bit after_lu = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    hazard_detection_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .if_id_uses_rs1  (if_id_uses_rs1),
        .if_id_uses_rs2  (if_id_uses_rs2),
        .id_ex_MemRead   (id_ex_MemRead),
        .id_ex_rd        (id_ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Write     (ID_EX_Write),
        .EX_MEM_Write    (EX_MEM_Write),
        .MEM_WB_Write    (MEM_WB_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    assign outs = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write, IF_ID_Flush, ID_EX_Flush};

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // What happens this cycle: 0 reset, 1 freeze, 2 branch flush, 3 load-use stall, 4 nothing.
    function automatic int model_cls();
        bit raw_lu;
        if (reset) return 0;
        if (mem_busy) return 1;
        if (ex_branch_taken) return 2;
        raw_lu = id_ex_MemRead && (id_ex_rd != 0)
              && ((if_id_uses_rs1 && if_id_rs1 == id_ex_rd) || (if_id_uses_rs2 && if_id_rs2 == id_ex_rd));
        if (raw_lu && !after_lu) return 3;
        return 4;
    endfunction

    function automatic logic [6:0] cls_outs(input int c);
        case (c)
            0:       return O_RESET;
            1:       return O_FREEZE;
            2:       return O_BRANCH;
            3:       return O_LU;
            default: return O_DEF;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        int c;
        if (reset) begin
            after_lu = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            c = model_cls();
            if ((c == 1 || c == 3) && m_stall < CMAX) m_stall++;
            if (c == 2 && m_flush < CMAX) m_flush++;
            after_lu = (c == 3);
        end
    end

    always @(negedge clk) begin
        chk("outs", int'(outs), int'(cls_outs(model_cls())));
        chk("stall_cycles", int'(stall_cycles), m_stall);
        chk("flush_count", int'(flush_count), m_flush);
    end

    // Applies inputs just after a rising edge, then settles 1 time unit for literal checks.
    task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2,
                         input bit mr, input int rd, input bit br, input bit mb);
        @(posedge clk);
        #1;
        if_id_rs1       = RW'(rs1);
        if_id_rs2       = RW'(rs2);
        if_id_uses_rs1  = u1;
        if_id_uses_rs2  = u2;
        id_ex_MemRead   = mr;
        id_ex_rd        = RW'(rd);
        ex_branch_taken = br;
        mem_busy        = mb;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
        if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0; id_ex_MemRead = 1'b0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0;
        #2;
        chk("reset_outs", int'(outs), int'(O_RESET));
        chk("reset_stall", int'(stall_cycles), 0);
        chk("reset_flush", int'(flush_count), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("post_reset_outs", int'(outs), int'(O_DEF));

        // Load-use on rs1 = x5: one stall cycle; held inputs must not stall again.
        drive(5, 0, 1, 0, 1, 5, 0, 0);
        chk("lu_outs", int'(outs), int'(O_LU));
        chk("lu_stall_before", int'(stall_cycles), 0);
        drive(5, 0, 1, 0, 1, 5, 0, 0);
        chk("lu_next_default", int'(outs), int'(O_DEF));
        chk("lu_stall_after", int'(stall_cycles), 1);
        idle();

        // No dependence: destination x0, or matching rs2 that is not read.
        drive(0, 0, 1, 1, 1, 0, 0, 0);
        chk("x0_no_stall", int'(outs), int'(O_DEF));
        drive(1, 7, 1, 0, 1, 7, 0, 0);
        chk("imm_no_stall", int'(outs), int'(O_DEF));

        // Taken branch together with lu: flush wins, no stall.
        drive(5, 0, 1, 0, 1, 5, 1, 0);
        chk("br_lu_outs", int'(outs), int'(O_BRANCH));
        chk("br_flush_before", int'(flush_count), 0);
        idle();
        chk("br_flush_after", int'(flush_count), 1);
        chk("br_stall_same", int'(stall_cycles), 1);
        chk("br_state_run", int'(outs), int'(O_DEF));

        // Memory busy 3 cycles with a branch pending; flush fires on cycle 4.
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("mem_freeze1", int'(outs), int'(O_FREEZE));
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("mem_freeze2", int'(outs), int'(O_FREEZE));
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("mem_freeze3", int'(outs), int'(O_FREEZE));
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mem_branch_after", int'(outs), int'(O_BRANCH));
        chk("mem_stall_count", int'(stall_cycles), 4);
        idle();
        chk("mem_flush_count", int'(flush_count), 2);

        // Async reset during LOAD_STALL, mid-cycle.
        drive(3, 0, 1, 0, 1, 3, 0, 0);
        idle();
        chk("in_load_stall", int'(outs), int'(O_DEF));
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outs", int'(outs), int'(O_RESET));
        chk("async_rst_stall", int'(stall_cycles), 0);
        chk("async_rst_flush", int'(flush_count), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("rst_release_def", int'(outs), int'(O_DEF));
        drive(9, 9, 0, 1, 1, 9, 0, 0);
        chk("no_stale_stall", int'(outs), int'(O_LU));

        // Saturation at 2^CW-1.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) drive(4, 0, 1, 0, 1, 4, 0, 0);
            else            idle();
        end
        idle();
        chk("stall_saturated", int'(stall_cycles), CMAX);
        drive(4, 0, 1, 0, 1, 4, 0, 0);
        idle();
        chk("stall_no_wrap", int'(stall_cycles), CMAX);

        // Randomized traffic; the negedge compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
        end

        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline hazard controller for the 5-stage RISC-V core. It complements the EX-stage forwarding unit: forwarding resolves RAW hazards by steering operands into EX, and this block resolves the hazards forwarding cannot. It stalls IF/ID for load-use dependences, flushes IF/ID and ID/EX on a taken branch, and freezes the whole pipeline while data memory is busy. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears state and counters
- if_id_rs1, if_id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- if_id_uses_rs1, if_id_uses_rs2  in  1  the ID instruction actually reads that source
- id_ex_MemRead  in  1  the instruction in EX is a load
- id_ex_rd  in  REG_ADDR_W  destination of the instruction in EX
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data memory has not completed its access this cycle
- PCWrite  out  1  PC register enable
- IF_ID_Write  out  1  IF/ID register enable
- ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1  downstream pipeline register enables
- IF_ID_Flush  out  1  load NOP into IF/ID
- ID_EX_Flush  out  1  zero control fields of ID/EX (bubble)
- stall_cycles  out  CNT_W  cycles with PCWrite=0 since reset
- flush_count  out  CNT_W  taken-branch flushes since reset

## Operation
- FSM states: RUN, LOAD_STALL, MEM_WAIT. State is registered. Outputs are combinational from the state and the current inputs.
- Load-use condition lu: id_ex_MemRead & (id_ex_rd != 0) & ((if_id_uses_rs1 & if_id_rs1 == id_ex_rd) | (if_id_uses_rs2 & if_id_rs2 == id_ex_rd)).
- Default outputs: all Write enables=1, flushes=0.
- Conditions are evaluated in priority order: mem_busy, then ex_branch_taken, then lu.
- RUN:
  - mem_busy=1: all five Write enables=0 and flushes=0. Next state is MEM_WAIT.
  - else ex_branch_taken=1: IF_ID_Flush=1 and ID_EX_Flush=1. PCWrite=1 so the target is loaded. Next state is RUN. Any lu is discarded.
  - else lu=1: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Next state is LOAD_STALL.
  - else: defaults, and the state stays RUN.
- LOAD_STALL: lasts one cycle. lu is forced to 0, because the bubble now occupies EX. The mem_busy and branch rules apply exactly as in RUN. Next state is RUN, or MEM_WAIT if mem_busy=1.
- MEM_WAIT:
  - mem_busy=1: full freeze, as above, and the state stays MEM_WAIT.
  - mem_busy=0: behave exactly as RUN in the same cycle, including the transitions.
- ex_branch_taken and lu are ignored while frozen. The held EX instruction re-presents them after the freeze.
- stall_cycles increments on each clock edge where PCWrite=0 and reset=0. flush_count increments on each edge where IF_ID_Flush=1 due to a branch.
- Both counters saturate at 2^CNT_W−1. They never wrap.

## Timing
- Hazard outputs have zero latency: they are combinational in the same cycle as the inputs.
- The state updates on the rising edge of clk.
- Counter outputs are registered and reflect events up to the previous edge.
- A load-use costs exactly 1 stall cycle.
- A taken branch costs 2 squashed instructions, with no stall cycle.
- A memory wait stalls for N cycles when mem_busy is high for N consecutive cycles.
- While reset=1:
  - state is RUN, counters are 0
  - PCWrite and all four downstream Write enables are 0
  - IF_ID_Flush=1 and ID_EX_Flush=1
- Reset asserted mid-stall or mid-freeze immediately overrides the above. Release resumes in RUN with no stale stall.
- If mem_busy and ex_branch_taken are high together, the freeze wins. The flush happens in the first cycle after mem_busy falls.

## Structure
- Shared package riscv_pipe_pkg holds:
  - the state encoding (RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2)
  - the REG_ADDR_W default
  - the X0 constant
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), is instantiated twice, for the two counters.
- The lu comparator and the output decode stay inline.

## Test plan
- Load to x5 in EX, ID reads rs1=x5 with uses_rs1=1 → in that cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. The next cycle is all defaults. stall_cycles goes 0→1.
- Same as above but id_ex_rd=x0, or the ID instruction is immediate-only with matching rs2 and uses_rs2=0 → no stall, all outputs at defaults.
- ex_branch_taken=1 together with lu=1 → IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, no stall. flush_count goes 0→1 and the state stays RUN.
- mem_busy high for 3 cycles, with a taken branch pending in the first → all Write enables=0 for 3 cycles and stall_cycles increases by 3. On the fourth cycle the branch flush fires.
- reset asserted during LOAD_STALL (asynchronously, mid-cycle) → outputs go to their reset values immediately and both counters read 0. After release the block is in RUN with default outputs.
- Drive CNT_W=4 and keep lu asserted every other cycle for 40 cycles → stall_cycles saturates at 15 and does not wrap.
